// File: rtl/iter_alu.sv
// Execute-stage ALU with registered result and a start/done handshake.
// Single-cycle ops finish in one cycle; MUL/DIV/REM iterate one bit per cycle.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_DIVU = 4'd8;
    localparam logic [3:0] OP_REM  = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW:0]     CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0]     CNT_ONE  = (SHW+1)'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_next;
    logic [SHW:0]     r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;      // multiplicand (shifted left) or |divisor|
    logic [WIDTH-1:0] r_b;      // multiplier (shifted right) or dividend -> quotient
    logic [WIDTH-1:0] r_acc;    // partial product or partial remainder
    logic             r_neg_q, r_neg_r;
    logic             r_done;
    logic [WIDTH-1:0] r_data;

    logic             w_accept, w_div_op, w_signed_div, w_div0, w_ovf, w_special;
    logic             w_go_run, w_single, w_last;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_single_res, w_abs1, w_abs2, w_mul_acc;
    logic [WIDTH:0]   w_rem_sh, w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next, w_quo_next, w_final;

    // A flush in IDLE drops a coincident start.
    assign w_accept     = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_div_op     = (ctrl_i >= OP_DIV) && (ctrl_i <= OP_REMU);
    assign w_signed_div = (ctrl_i == OP_DIV) || (ctrl_i == OP_REM);
    assign w_div0       = (data2_i == '0);
    assign w_ovf        = w_signed_div && (data1_i == MOST_NEG) && (data2_i == '1);
    assign w_special    = w_div_op && (w_div0 || w_ovf);
    assign w_go_run     = w_accept && ((ctrl_i == OP_MUL) || (w_div_op && !w_special));
    assign w_single     = w_accept && !w_go_run;
    assign w_last       = (r_state == S_RUN) && !flush_i && (r_cnt == CNT_ONE);
    assign w_shamt      = data2_i[SHW-1:0];

    assign w_abs1 = (w_signed_div && data1_i[WIDTH-1]) ? -data1_i : data1_i;
    assign w_abs2 = (w_signed_div && data2_i[WIDTH-1]) ? -data2_i : data2_i;

    // Single-cycle results, including the divide special cases.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_single_res = '0;
        case (ctrl_i)
            OP_ADD:           w_single_res = data1_i + data2_i;
            OP_SUB:           w_single_res = data1_i - data2_i;
            OP_AND:           w_single_res = data1_i & data2_i;
            OP_XOR:           w_single_res = data1_i ^ data2_i;
            OP_SLL:           w_single_res = data1_i << w_shamt;
            OP_SRA:           w_single_res = $signed(data1_i) >>> w_shamt;
            OP_DIV, OP_DIVU:  w_single_res = w_div0 ? '1 : data1_i;
            OP_REM, OP_REMU:  w_single_res = w_div0 ? data1_i : '0;
            default:          w_single_res = '0;
        endcase
    end

    // One iteration step of shift-add multiply and restoring divide.
    assign w_mul_acc  = r_acc + (r_b[0] ? r_a : '0);
    assign w_rem_sh   = {r_acc, r_b[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_a};
    assign w_qbit     = !w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_next = {r_b[WIDTH-2:0], w_qbit};

    always_comb begin
        w_final = w_mul_acc;
        if (r_op == OP_DIV || r_op == OP_DIVU)
            w_final = r_neg_q ? -w_quo_next : w_quo_next;
        else if (r_op == OP_REM || r_op == OP_REMU)
            w_final = r_neg_r ? -w_rem_next : w_rem_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_go_run) w_state_next = S_RUN;
            S_RUN:  if (flush_i || r_cnt == CNT_ONE) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_single) begin
                r_data <= w_single_res;
                r_done <= 1'b1;
            end else if (w_go_run) begin
                r_op    <= ctrl_i;
                r_cnt   <= CNT_INIT;
                r_acc   <= '0;
                r_a     <= (ctrl_i == OP_MUL) ? data1_i : w_abs2;
                r_b     <= (ctrl_i == OP_MUL) ? data2_i : w_abs1;
                r_neg_q <= w_signed_div && (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
                r_neg_r <= w_signed_div && data1_i[WIDTH-1];
            end else if (r_state == S_RUN) begin
                if (flush_i) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_op == OP_MUL) begin
                        r_acc <= w_mul_acc;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end else begin
                        r_acc <= w_rem_next;
                        r_b   <= w_quo_next;
                    end
                    if (w_last) begin
                        r_data <= w_final;
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy_o = (r_state == S_RUN);
    assign done_o = r_done;
    assign data_o = r_data;
endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed cases plus random ops against
// an arithmetic reference model, on a 32-bit and an 8-bit instance.
module tb_iter_alu;
    localparam logic [3:0] ADD = 0, SUB = 1, AND_ = 2, XOR_ = 3, SLL = 4, SRA = 5;
    localparam logic [3:0] MUL = 6, DIV = 7, DIVU = 8, REM = 9, REMU = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, flush, busy, done;
    logic [3:0]  ctrl;
    logic [31:0] d1, d2, dout;
    logic        rst8, start8, flush8, busy8, done8;
    logic [3:0]  ctrl8;
    logic [7:0]  e1, e2, dout8;

    int n_checks = 0;
    int n_errors = 0;

    iter_alu #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
        .data1_i(d1), .data2_i(d2), .flush_i(flush),
        .busy_o(busy), .done_o(done), .data_o(dout)
    );

    iter_alu #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst8), .start_i(start8), .ctrl_i(ctrl8),
        .data1_i(e1), .data2_i(e2), .flush_i(flush8),
        .busy_o(busy8), .done_o(done8), .data_o(dout8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain signed/unsigned arithmetic on a w-bit word.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w, output int lat);
        longint mask, half, ua, ub, sa, sb, r;
        bit special;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= half) ? ua - (mask + 1) : ua;
        sb = (ub >= half) ? ub - (mask + 1) : ub;
        special = (op >= DIV && op <= REMU && ub == 0) ||
                  ((op == DIV || op == REM) && sa == -half && sb == -1);
        case (op)
            ADD:  r = ua + ub;
            SUB:  r = ua - ub;
            AND_: r = ua & ub;
            XOR_: r = ua ^ ub;
            SLL:  r = ua << (ub % w);
            SRA:  r = sa >>> (ub % w);
            MUL:  r = ua * ub;
            DIV:  r = (ub == 0) ? mask : (special ? ua : sa / sb);
            REM:  r = (ub == 0) ? ua   : (special ? 0  : sa % sb);
            DIVU: r = (ub == 0) ? mask : ua / ub;
            REMU: r = (ub == 0) ? ua   : ua % ub;
            default: r = 0;
        endcase
        lat = (op >= MUL && op <= REMU && !special) ? w + 1 : 1;
        return 32'(r & mask);
    endfunction

    task automatic drive(input bit w8, input logic s, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            start8 = s; ctrl8 = op; e1 = a[7:0]; e2 = b[7:0];
        end else begin
            start = s; ctrl = op; d1 = a; d2 = b;
        end
    endtask

    task automatic sample(input bit w8, output logic bz, output logic dn, output logic [31:0] q);
        bz = w8 ? busy8 : busy;
        dn = w8 ? done8 : done;
        q  = w8 ? {24'h0, dout8} : dout;
    endtask

    // Issue one op, then check latency, busy window, result and pulse width.
    task automatic run_op(input string tag, input bit w8, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int busy_cnt = 0;
        int seen_at = 0;
        logic bz, dn;
        logic [31:0] q;
        @(negedge clk);
        drive(w8, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, op, a, b);
        for (int k = 1; k <= lat + 4; k++) begin
            @(negedge clk);
            sample(w8, bz, dn, q);
            if (dn) begin
                seen_at = k;
                break;
            end
            if (bz) busy_cnt++;
        end
        check({tag, " done_seen"}, seen_at != 0, 1);
        if (seen_at != 0) begin
            check({tag, " latency"}, seen_at, lat);
            check({tag, " data"}, q, exp);
            check({tag, " busy_at_done"}, bz, 0);
            check({tag, " busy_cycles"}, busy_cnt, lat - 1);
            @(negedge clk);
            sample(w8, bz, dn, q);
            check({tag, " done_pulse"}, dn, 0);
            check({tag, " data_hold"}, q, exp);
        end
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask, v;
        mask = (w == 32) ? 32'hFFFF_FFFF : (32'h1 << w) - 1;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = '1;
            2: v = 32'h1 << (w - 1);
            3: v = $urandom_range(0, 15);
            default: v = $urandom();
        endcase
        return v & mask;
    endfunction

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, exp;
        int lat;
        rst = 1; start = 0; flush = 0; ctrl = 0; d1 = 0; d2 = 0;
        rst8 = 1; start8 = 0; flush8 = 0; ctrl8 = 0; e1 = 0; e2 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset data", dout, 0);
        check("reset8 busy", busy8, 0);
        check("reset8 done", done8, 0);
        check("reset8 data", dout8, 0);
        rst = 0; rst8 = 0;

        // Back-to-back single-cycle ops.
        @(negedge clk);
        start = 1; ctrl = ADD; d1 = 5; d2 = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        ctrl = XOR_; d1 = 32'hF0F0_0000; d2 = 32'h0FF0_0001;
        @(negedge clk);
        check("b2b add done", done, 1);
        check("b2b add data", dout, 2);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check("b2b xor done", done, 1);
        check("b2b xor data", dout, 32'hFF00_0001);
        @(negedge clk);
        check("b2b idle done", done, 0);

        run_op("sra",      0, SRA,  32'h8000_0000, 32'h24,        32'hF800_0000, 1);
        run_op("mul -3*7", 0, MUL,  32'hFFFF_FFFD, 7,             32'hFFFF_FFEB, 33);
        run_op("mul -1*-1",0, MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         33);
        run_op("div -7/2", 0, DIV,  32'hFFFF_FFF9, 2,             32'hFFFF_FFFD, 33);
        run_op("rem -7/2", 0, REM,  32'hFFFF_FFF9, 2,             32'hFFFF_FFFF, 33);
        run_op("divu",     0, DIVU, 32'hFFFF_FFF9, 2,             32'h7FFF_FFFC, 33);
        run_op("remu",     0, REMU, 32'hFFFF_FFF9, 2,             32'h1,         33);
        run_op("div 5/0",  0, DIV,  5,             0,             32'hFFFF_FFFF, 1);
        run_op("remu 5/0", 0, REMU, 5,             0,             32'h5,         1);
        run_op("div ovf",  0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf",  0, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
        run_op("reserved", 0, 4'd12, 32'h1234,     32'h5678,      32'h0,         1);
        run_op("pre-flush",0, ADD,  100,           23,            32'd123,       1);

        // Flush mid-MUL; starts while busy must be ignored.
        @(negedge clk);
        drive(0, 1'b1, MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        start = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("flush run busy", busy, 1);
            check("flush run done", done, 0);
            if (k >= 2 && k <= 9) drive(0, 1'b1, ADD, $urandom(), $urandom());
            else if (k == 10) begin
                start = 0;
                flush = 1;
            end
        end
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        check("flush busy", busy, 0);
        check("flush done", done, 0);
        check("flush data kept", dout, 123);
        drive(0, 1'b1, ADD, 7, 8);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check("post-flush add done", done, 1);
        check("post-flush add data", dout, 15);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post-flush quiet", done, 0);
        end

        // 8-bit instance.
        run_op("divu8", 1, DIVU, 200, 7, 28, 9);
        run_op("remu8", 1, REMU, 200, 7, 4,  9);
        @(negedge clk);
        drive(1, 1'b1, DIVU, 200, 7);
        @(posedge clk); #1;
        start8 = 0;
        repeat (4) @(negedge clk);
        check("rst8 pre busy", busy8, 1);
        rst8 = 1;
        @(posedge clk); #1;
        rst8 = 0;
        @(negedge clk);
        check("rst8 busy", busy8, 0);
        check("rst8 done", done8, 0);
        check("rst8 data", dout8, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rst8 no done", done8, 0);
        end

        // Random ops against the reference model.
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick(32);
            b = pick(32);
            exp = model(op, a, b, 32, lat);
            run_op($sformatf("rnd32 op%0d", op), 0, op, a, b, exp, lat);
        end
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick(8);
            b = pick(8);
            exp = model(op, a, b, 8, lat);
            run_op($sformatf("rnd8 op%0d", op), 1, op, a, b, exp, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
